fetch_issue_unit: RTL
=====================

FETCH_ISSUE_UNIT -- requirements
Module: fetch_issue_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: run  in  1  level; 1 = fetch enabled, 0 = stop after current instruction retires.
REQ-004 SHALL have: imem_addr  out  8  instruction memory address (program counter).
REQ-005 SHALL have: imem_rd  out  1  read strobe; imem_data valid exactly one cycle later.
REQ-006 SHALL have: imem_data  in  8  instruction word {opcode[7:4], rs[3:2], rt[1:0]}.
REQ-007 SHALL have: instruction  out  8  registered word presented to the decoder.
REQ-008 SHALL have: instr_valid  out  1 / instr_ready  in  1  issue handshake to the decoder/datapath.
REQ-009 SHALL have: branch_taken  in  1  compare result for beq/bne, sampled in EXEC.
REQ-010 SHALL have: target_addr  in  8  redirect target for j/jal/beq/bne, sampled in EXEC.
REQ-011 SHALL have: mem_done  in  1  data-memory completion for lw/sw.
REQ-012 SHALL have: link_addr  out  8 / link_we  out  1  return address (PC+1) and 1-cycle write pulse for jal.
REQ-013 SHALL have: busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, LATCH, ISSUE, EXEC, MEM_WAIT.
REQ-015 IDLE -> FETCH when run=1; otherwise hold, imem_rd=0, instr_valid=0.
REQ-016 FETCH: imem_addr=pc, imem_rd=1 for one cycle; next LATCH.
REQ-017 LATCH: instruction <= imem_data; next ISSUE.
REQ-018 ISSUE: instr_valid=1, instruction held stable until instr_valid&&instr_ready; transfer cycle -> EXEC.
REQ-019 EXEC, opcodes 0000-0111, 1110, 1111: pc <= pc+1; next FETCH (or IDLE if run=0).
REQ-020 EXEC, 1000 (j): pc <= target_addr.
REQ-021 EXEC, 1001 (jal): pc <= target_addr; link_addr=pc+1, link_we=1 for that single cycle.
REQ-022 EXEC, 1100 (beq) / 1101 (bne): pc <= target_addr if branch_taken=1, else pc+1.
REQ-023 EXEC, 1010 (lw) / 1011 (sw): -> MEM_WAIT; pc unchanged until mem_done.
REQ-024 MEM_WAIT: on mem_done=1, pc <= pc+1, -> FETCH (or IDLE if run=0); else hold.
REQ-025 pc arithmetic SHALL be 8-bit modulo: pc=8'hFF +1 wraps to 8'h00; jal from 8'hFF gives link_addr=8'h00.
REQ-026 Minimum sequential instruction period SHALL be 4 cycles (FETCH, LATCH, ISSUE with ready=1, EXEC).
REQ-027 run falling mid-instruction SHALL NOT abort it; stop is checked only at EXEC/MEM_WAIT exit.
REQ-028 mem_done asserted outside MEM_WAIT and branch_taken outside EXEC SHALL be ignored.
REQ-029 link_we SHALL never assert for any opcode other than 1001.

Reset
REQ-030 rst=1 SHALL immediately force: state=IDLE, pc=8'h00, instruction=8'h00, imem_rd=0, instr_valid=0, link_we=0, link_addr=8'h00, busy=0.
REQ-031 Reset asserted mid-instruction (any state) SHALL discard the instruction; no link_we pulse, no pc update.
REQ-032 First fetch after reset release SHALL be address 8'h00 on the first edge with run=1.

Structure
REQ-033 Opcode constants (MOVE..LI, 4'b0000..4'b1111) and FSM state encodings SHALL live in a shared ISA package used also by the control unit.
REQ-034 The program counter with increment/load/wrap SHALL be a sub-module named pc_reg; FSM stays in fetch_issue_unit.

Verification
REQ-035 Reset, run=1, imem returns 0x1D at 0x00, ready=1 -> imem_addr 0x00, instruction=0x1D valid 2 cycles after imem_rd, next fetch at 0x01.
REQ-036 instr_ready held 0 for 5 cycles -> instr_valid and instruction=0x2D stable for all 5, pc unchanged.
REQ-037 jal (0x9D) at pc=0x10, target_addr=0x40 -> link_we one cycle, link_addr=0x11, next imem_addr=0x40.
REQ-038 beq (0xCD) at 0x20 with branch_taken=0 -> next 0x21; with branch_taken=1, target 0x05 -> next 0x05.
REQ-039 lw (0xAD), mem_done after 3 cycles -> no fetch during MEM_WAIT, next imem_addr=pc+1; pc=0xFF addi -> next 0x00.
REQ-040 rst pulsed during MEM_WAIT -> all outputs to reset values asynchronously, later fetch restarts at 0x00.

Source files
------------

// File: rtl/fetch_issue_unit_pkg.sv
// fetch_issue_unit_pkg: ISA opcodes and fetch/issue FSM encodings shared with the control unit.
package fetch_issue_unit_pkg;
    typedef enum logic [3:0] {
        OP_MOVE = 4'b0000, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI,
        OP_J, OP_JAL, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI, OP_LI
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_EXEC, S_MEM_WAIT
    } state_e;

    function automatic logic is_branch(opcode_e op);
        return op == OP_BEQ || op == OP_BNE;
    endfunction

    function automatic logic is_mem(opcode_e op);
        return op == OP_LW || op == OP_SW;
    endfunction
endpackage

// File: rtl/fetch_issue_unit_pc_reg.sv
// pc_reg: 8-bit program counter with load and modulo-256 increment.
module pc_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] pc,
    output logic [7:0] pc_inc
);
    assign pc_inc = pc + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= 8'h00;
        else if (load) pc <= load_val;
        else if (inc) pc <= pc_inc;
    end
endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: fetches, latches and issues one instruction at a time, then redirects or advances the pc.
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic [7:0] imem_addr,
    output logic       imem_rd,
    input  logic [7:0] imem_data,
    output logic [7:0] instruction,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_taken,
    input  logic [7:0] target_addr,
    input  logic       mem_done,
    output logic [7:0] link_addr,
    output logic       link_we,
    output logic       busy
);
    state_e     state;
    opcode_e    op;
    logic [7:0] pc;
    logic [7:0] pc_inc;
    logic       mem_op;
    logic       jump;
    logic       retire;

    assign op        = opcode_e'(instruction[7:4]);
    assign mem_op    = is_mem(op);
    assign jump      = op == OP_J || op == OP_JAL || (is_branch(op) && branch_taken);
    // an instruction retires on leaving EXEC, or leaving MEM_WAIT for loads/stores
    assign retire    = state == S_EXEC ? !mem_op : state == S_MEM_WAIT && mem_done;
    assign imem_addr = pc;

    pc_reg u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (retire && !(state == S_EXEC && jump)),
        .load     (state == S_EXEC && jump),
        .load_val (target_addr),
        .pc       (pc),
        .pc_inc   (pc_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            instruction <= 8'h00;
            imem_rd     <= 1'b0;
            instr_valid <= 1'b0;
            link_we     <= 1'b0;
            link_addr   <= 8'h00;
            busy        <= 1'b0;
        end else begin
            imem_rd <= 1'b0;
            link_we <= 1'b0;
            case (state)
                S_IDLE: if (run) begin
                    state   <= S_FETCH;
                    imem_rd <= 1'b1;
                    busy    <= 1'b1;
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    instruction <= imem_data;
                    instr_valid <= 1'b1;
                    state       <= S_ISSUE;
                end
                S_ISSUE: if (instr_ready) begin
                    instr_valid <= 1'b0;
                    state       <= S_EXEC;
                    // link pulse is registered here so it is high exactly during EXEC
                    if (op == OP_JAL) begin
                        link_we   <= 1'b1;
                        link_addr <= pc_inc;
                    end
                end
                S_EXEC, S_MEM_WAIT: if (retire) begin
                    state   <= run ? S_FETCH : S_IDLE;
                    imem_rd <= run;
                    busy    <= run;
                end else if (state == S_EXEC) begin
                    state <= S_MEM_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
